// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the register-file write path.
// Imported by the write scheduler and its testbench.
package regfile_pkg;

  typedef enum logic {INIT, RUN} state_e;

  localparam int DefaultRegisterWidth = 32;
  localparam int DefaultNRegisters    = 32;
  localparam int DropCountWidth       = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after rrPtr wins.
// Zero latency; grant is only ever given to a requester whose valid is high.
module rr_arbiter #(
  parameter  int N    = 3,
  localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    reqValid,
  input  logic [IdxW-1:0] rrPtr,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] grantIdx,
  output logic            grantVld
);

  int idx;

  always_comb begin
    grant    = '0;
    grantIdx = '0;
    grantVld = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rrPtr) + k) % N;
      if (!grantVld && reqValid[idx]) begin
        grantVld    = 1'b1;
        grant[idx]  = 1'b1;
        grantIdx    = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Owns the register-file write port: zeroes r1..rN-1 after reset, then shares the
// port round-robin between writeback sources with a zero-latency combinational grant.
module regfile_write_scheduler
  import regfile_pkg::*;
#(
  parameter  int RegisterWidth = DefaultRegisterWidth,
  parameter  int NRegisters    = DefaultNRegisters,
  parameter  int NRequesters   = 3,
  localparam int AddrWidth     = $clog2(NRegisters),
  localparam int IdxW          = (NRequesters > 1) ? $clog2(NRequesters) : 1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NRequesters-1:0]                     reqValid,
  input  logic [NRequesters-1:0][AddrWidth-1:0]      reqAddr,
  input  logic [NRequesters-1:0][RegisterWidth-1:0]  reqData,
  output logic [NRequesters-1:0]                     reqReady,
  output logic                                       wEn,
  output logic [AddrWidth-1:0]                       wAddr,
  output logic [RegisterWidth-1:0]                   wData,
  output logic                                       initDone,
  output logic [DropCountWidth-1:0]                  dropCount
);

  state_e                    state_q;
  logic [AddrWidth-1:0]      initPtr_q;
  logic [IdxW-1:0]           rrPtr_q, rrPtr_d;
  logic [DropCountWidth-1:0] dropCount_q;

  logic [NRequesters-1:0]    grant;
  logic [IdxW-1:0]           gIdx;
  logic                      gVld;
  logic [AddrWidth-1:0]      selAddr;
  logic [RegisterWidth-1:0]  selData;
  logic                      addrOk;
  logic                      handshake;

  rr_arbiter #(.N(NRequesters)) u_arb (
    .reqValid (reqValid),
    .rrPtr    (rrPtr_q),
    .grant    (grant),
    .grantIdx (gIdx),
    .grantVld (gVld)
  );

  always_comb begin
    selAddr   = reqAddr[gIdx];
    selData   = reqData[gIdx];
    addrOk    = (selAddr != '0) && ({1'b0, selAddr} < (AddrWidth+1)'(NRegisters));
    handshake = (state_q == RUN) && gVld;
    rrPtr_d   = (gIdx == IdxW'(NRequesters - 1)) ? '0 : gIdx + IdxW'(1);
  end

  // Outputs are gated by reset directly so they fall without waiting for a clock edge.
  always_comb begin
    reqReady = '0;
    wEn      = 1'b0;
    wAddr    = '0;
    wData    = '0;
    initDone = 1'b0;
    if (reset) begin
      if (state_q == INIT) begin
        wEn   = 1'b1;
        wAddr = initPtr_q;
      end else begin
        initDone = 1'b1;
        reqReady = grant;
        wEn      = gVld && addrOk;
        if (gVld) begin
          wAddr = selAddr;
          wData = selData;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= INIT;
      initPtr_q   <= AddrWidth'(1);
      rrPtr_q     <= '0;
      dropCount_q <= '0;
    end else begin
      case (state_q)
        INIT: begin
          initPtr_q <= initPtr_q + AddrWidth'(1);
          if (initPtr_q == AddrWidth'(NRegisters - 1)) state_q <= RUN;
        end
        RUN: begin
          if (handshake) begin
            rrPtr_q <= rrPtr_d;
            if (!addrOk && dropCount_q != '1) dropCount_q <= dropCount_q + DropCountWidth'(1);
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign dropCount = dropCount_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: directed vector table, reset/INIT corner sequences,
// and a randomized run against a behavioural model of sweep, round-robin and drop counting.
module tb_regfile_write_scheduler;

  localparam int NR   = 3;
  localparam int NREG = 32;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [NR-1:0]        reqValid;
  logic [NR-1:0][4:0]   reqAddr;
  logic [NR-1:0][31:0]  reqData;
  logic [NR-1:0]        reqReady;
  logic                 wEn;
  logic [4:0]           wAddr;
  logic [31:0]          wData;
  logic                 initDone;
  logic [7:0]           dropCount;

  int checks = 0;
  int failures = 0;

  logic [31:0] rf [NREG];
  logic        scramble = 1'b0;

  logic        m_init;
  int          m_ptr, m_rr, m_drop;
  logic [31:0] m_regs [NREG];

  typedef struct {
    logic [2:0]  v;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [2:0]  rdy;
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    int          drop;
  } vec_t;

  vec_t tbl [13];

  regfile_write_scheduler #(.RegisterWidth(32), .NRegisters(NREG), .NRequesters(NR)) dut (
    .clk       (clk),
    .reset     (reset),
    .reqValid  (reqValid),
    .reqAddr   (reqAddr),
    .reqData   (reqData),
    .reqReady  (reqReady),
    .wEn       (wEn),
    .wAddr     (wAddr),
    .wData     (wData),
    .initDone  (initDone),
    .dropCount (dropCount)
  );

  always #5 clk = ~clk;

  // Register file as seen from the write port; scramble gives it junk before the sweep.
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < NREG; i++) rf[i] <= 32'hA5A5_0000 + i;
    end else if (wEn) begin
      rf[wAddr] <= wData;
    end
  end

  function automatic logic [63:0] mk(input logic [2:0] r, input logic e, input logic [4:0] a,
                                     input logic [31:0] d, input logic done);
    return {22'd0, r, e, a, d, done};
  endfunction

  function automatic logic [63:0] obs(input bit full);
    logic [63:0] v;
    v = {22'd0, reqReady, wEn, wAddr, wData, initDone};
    if (!full) v[37:1] = '0;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 1'b1;
    m_ptr  = 1;
    m_rr   = 0;
    m_drop = 0;
  endtask

  task automatic model_cycle(input int cyc, output int g);
    logic [63:0] exp;
    bit          bad;
    g   = -1;
    bad = 1'b0;
    if (m_init) begin
      exp = mk(3'b000, 1'b1, 5'(m_ptr), 32'd0, 1'b0);
    end else begin
      for (int k = 0; k < NR; k++)
        if (g < 0 && reqValid[(m_rr + k) % NR]) g = (m_rr + k) % NR;
      if (g >= 0) begin
        bad = (reqAddr[g] == 0) || (int'(reqAddr[g]) >= NREG);
        exp = mk(3'(1 << g), !bad, reqAddr[g], reqData[g], 1'b1);
      end else begin
        exp = mk(3'b000, 1'b0, 5'd0, 32'd0, 1'b1);
      end
    end
    check($sformatf("rand_out c%0d", cyc), obs(m_init || g >= 0), exp);
    check($sformatf("rand_drop c%0d", cyc), {56'd0, dropCount}, 64'(m_drop));
    if (m_init) begin
      m_regs[m_ptr] = 32'd0;
      if (m_ptr == NREG - 1) m_init = 1'b0;
      m_ptr++;
    end else if (g >= 0) begin
      m_rr = (g + 1) % NR;
      if (bad) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      else     m_regs[reqAddr[g]] = reqData[g];
    end
  endtask

  task automatic new_req(input int i);
    reqValid[i] = ($urandom_range(0, 99) < 60);
    reqAddr[i]  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, NREG - 1));
    reqData[i]  = $urandom;
  endtask

  initial begin
    int g;
    reqValid = '0;
    reqAddr  = '0;
    reqData  = '0;

    tbl[0]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h10, 32'h11, 32'h12, 3'b001, 1'b1, 5'd1, 32'h10, 0};
    tbl[1]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h10, 32'h11, 32'h12, 3'b010, 1'b1, 5'd2, 32'h11, 0};
    tbl[2]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h10, 32'h11, 32'h12, 3'b100, 1'b1, 5'd3, 32'h12, 0};
    tbl[3]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h10, 32'h11, 32'h12, 3'b001, 1'b1, 5'd1, 32'h10, 0};
    tbl[4]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h10, 32'h11, 32'h12, 3'b010, 1'b1, 5'd2, 32'h11, 0};
    tbl[5]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h10, 32'h11, 32'h12, 3'b100, 1'b1, 5'd3, 32'h12, 0};
    tbl[6]  = '{3'b011, 5'd1, 5'd2, 5'd0, 32'h10, 32'h11, 32'h0,  3'b001, 1'b1, 5'd1, 32'h10, 0};
    tbl[7]  = '{3'b010, 5'd0, 5'd2, 5'd0, 32'h0,  32'h11, 32'h0,  3'b010, 1'b1, 5'd2, 32'h11, 0};
    tbl[8]  = '{3'b010, 5'd0, 5'd5, 5'd0, 32'h0,  32'hDEADBEEF, 32'h0, 3'b010, 1'b1, 5'd5, 32'hDEADBEEF, 0};
    tbl[9]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0,  32'h0,  3'b000, 1'b0, 5'd0, 32'h0,  0};
    tbl[10] = '{3'b001, 5'd0, 5'd0, 5'd0, 32'h55, 32'h0,  32'h0,  3'b001, 1'b0, 5'd0, 32'h55, 0};
    tbl[11] = '{3'b100, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0,  32'h66, 3'b100, 1'b0, 5'd0, 32'h66, 1};
    tbl[12] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0,  32'h0,  3'b000, 1'b0, 5'd0, 32'h0,  2};

    // Reset state, then the plain sweep with no requesters.
    repeat (2) @(posedge clk);
    #4;
    check("reset_out", obs(1'b1), mk(3'b000, 1'b0, 5'd0, 32'd0, 1'b0));
    check("reset_drop", {56'd0, dropCount}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    #3;
    for (int c = 1; c <= NREG - 1; c++) begin
      check($sformatf("sweep c%0d", c), obs(1'b1), mk(3'b000, 1'b1, 5'(c), 32'd0, 1'b0));
      @(posedge clk);
      #4;
    end
    check("init_done", obs(1'b0), mk(3'b000, 1'b0, 5'd0, 32'd0, 1'b1));

    // Directed RUN vectors: rotation, single writer, bad addresses.
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1;
      reqValid = tbl[i].v;
      reqAddr[0] = tbl[i].a0; reqAddr[1] = tbl[i].a1; reqAddr[2] = tbl[i].a2;
      reqData[0] = tbl[i].d0; reqData[1] = tbl[i].d1; reqData[2] = tbl[i].d2;
      #3;
      check($sformatf("vec%0d_out", i), obs(tbl[i].rdy != 0),
            mk(tbl[i].rdy, tbl[i].wen, tbl[i].wa, tbl[i].wd, 1'b1));
      check($sformatf("vec%0d_drop", i), {56'd0, dropCount}, 64'(tbl[i].drop));
      if (i == 9) check("rf_r5_readback", {32'd0, rf[5]}, 64'hDEADBEEF);
    end

    // Drop counter saturation.
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1 reqValid = 3'b001; reqAddr[0] = 5'd0; reqData[0] = 32'(i);
      #3;
      if (i == 100) check("drop_mid", {56'd0, dropCount}, 64'd102);
    end
    @(posedge clk);
    #1 reqValid = '0;
    #3;
    check("drop_sat", {56'd0, dropCount}, 64'd255);

    // Reset mid-sweep, then a requester waiting through the full restarted sweep.
    @(posedge clk);
    #1 reset = 1'b0;
    #3;
    check("rst2_out", obs(1'b1), mk(3'b000, 1'b0, 5'd0, 32'd0, 1'b0));
    check("rst2_drop", {56'd0, dropCount}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    reqValid = 3'b100; reqAddr[2] = 5'd7; reqData[2] = 32'hCAFE0007;
    #3;
    for (int c = 1; c <= 9; c++) begin
      check($sformatf("sweep2 c%0d", c), obs(1'b1), mk(3'b000, 1'b1, 5'(c), 32'd0, 1'b0));
      @(posedge clk);
      #4;
    end
    check("sweep2 c10", obs(1'b1), mk(3'b000, 1'b1, 5'd10, 32'd0, 1'b0));
    #1 reset = 1'b0;
    #1;
    check("async_rst_out", obs(1'b1), mk(3'b000, 1'b0, 5'd0, 32'd0, 1'b0));
    @(posedge clk);
    #1 reset = 1'b1;
    #3;
    for (int c = 1; c <= NREG - 1; c++) begin
      check($sformatf("sweep3 c%0d", c), obs(1'b1), mk(3'b000, 1'b1, 5'(c), 32'd0, 1'b0));
      @(posedge clk);
      #4;
    end
    check("first_run_grant", obs(1'b1), mk(3'b100, 1'b1, 5'd7, 32'hCAFE0007, 1'b1));
    @(posedge clk);
    #1 reqValid = '0;

    // Randomized traffic against the behavioural model, from a fresh reset.
    @(posedge clk);
    #1 reset = 1'b0; scramble = 1'b1;
    @(posedge clk);
    #1 scramble = 1'b0;
    model_reset();
    for (int i = 0; i < NR; i++) new_req(i);
    reset = 1'b1;
    #3;
    for (int c = 0; c < 600; c++) begin
      model_cycle(c, g);
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++)
        if (!reqValid[i] || g == i) new_req(i);
      #3;
    end
    reqValid = '0;
    @(posedge clk);
    #4;
    for (int r = 1; r < NREG; r++)
      check($sformatf("rf_r%0d", r), {32'd0, rf[r]}, {32'd0, m_regs[r]});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
